// File: rtl/if_id_fetch.sv
// rtl/if_id_fetch.sv - instruction fetch stage with IF/ID pipeline register
// Optional macro PERF_CNT_EN adds saturating stall/flush performance counters.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dpc_control,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_inst,
  output logic        ID_valid
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] id_pc_next, id_inst_next;
  logic        id_valid_next;
  logic [31:0] target_aligned;

  assign target_aligned = ex_target & ~32'd3;
  // Address comes straight from the registered pc; no path from imem_rdata.
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      ID_pc    <= 32'h0;
      ID_inst  <= NOP_INST;
      ID_valid <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ID_pc    <= id_pc_next;
      ID_inst  <= id_inst_next;
      ID_valid <= id_valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    id_pc_next    = ID_pc;
    id_inst_next  = ID_inst;
    id_valid_next = ID_valid;
    imem_req      = 1'b0;
    case (state)
      BOOT: begin
        state_next    = RUN;
        id_inst_next  = NOP_INST;
        id_valid_next = 1'b0;
        if (ex_redirect) pc_next = target_aligned;
      end
      RUN, WAIT: begin
        imem_req = 1'b1;
        if (ex_redirect) begin
          pc_next       = target_aligned;
          id_inst_next  = NOP_INST;
          id_valid_next = 1'b0;
          state_next    = RUN;
        end else if (dpc_control) begin
          // Hold everything; the same pc is refetched next cycle.
          state_next = state;
        end else if (!imem_ready) begin
          // Bubble keeps ID_pc so downstream sees ID_pc==EX_pc and skips forwarding.
          id_inst_next  = NOP_INST;
          id_valid_next = 1'b0;
          state_next    = WAIT;
        end else begin
          id_pc_next    = pc;
          id_inst_next  = imem_rdata;
          id_valid_next = 1'b1;
          pc_next       = pc + 32'd4;
          state_next    = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

`ifdef PERF_CNT_EN
  logic stall_hit;
  assign stall_hit = (state != BOOT) && dpc_control && !ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (stall_hit && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ex_redirect && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// tb/tb_if_id_fetch.sv - randomized self-checking bench for if_id_fetch
// Reference model tracks architectural pc / ID contents by the priority rules.
module tb_if_id_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dpc_control = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] ID_pc;
  logic [31:0] ID_inst;
  logic        ID_valid;
`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_id_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .dpc_control(dpc_control),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .ID_pc(ID_pc), .ID_inst(ID_inst), .ID_valid(ID_valid)
`ifdef PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_id_pc, m_id_inst, m_stall, m_flush;
  logic        m_valid, m_boot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_id_pc = 32'h0; m_id_inst = NOP_INST;
    m_valid = 1'b0; m_boot = 1'b1; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  imem_addr, m_pc);
    check({tag, ".req"},   {31'b0, imem_req}, {31'b0, !m_boot});
    check({tag, ".idpc"},  ID_pc, m_id_pc);
    check({tag, ".inst"},  ID_inst, m_id_inst);
    check({tag, ".valid"}, {31'b0, ID_valid}, {31'b0, m_valid});
`ifdef PERF_CNT_EN
    check({tag, ".pstall"}, perf_stall_cnt, m_stall);
    check({tag, ".pflush"}, perf_flush_cnt, m_flush);
`endif
  endtask

  // One clock: apply inputs, advance the model by the stage's priority rules, compare.
  task automatic step(input logic dpc, input logic redir, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rdata, input string tag);
    dpc_control = dpc; ex_redirect = redir; ex_target = tgt;
    imem_ready = rdy; imem_rdata = rdata;
    @(posedge clk);
    if (redir && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (m_boot) begin
      m_boot = 1'b0;
      m_id_inst = NOP_INST; m_valid = 1'b0;
      if (redir) m_pc = {tgt[31:2], 2'b00};
    end else if (redir) begin
      m_pc = {tgt[31:2], 2'b00};
      m_id_inst = NOP_INST; m_valid = 1'b0;
    end else if (dpc) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end else if (!rdy) begin
      m_id_inst = NOP_INST; m_valid = 1'b0;
    end else begin
      m_id_pc = m_pc; m_id_inst = rdata; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst.valid", {31'b0, ID_valid}, 32'h0);
    check("async_rst.addr", imem_addr, RESET_PC);
    check("async_rst.req", {31'b0, imem_req}, 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    check_all("boot");
  endtask

  initial begin
    logic [31:0] saved_id_pc, saved_inst;
    logic d, r, y;
    model_reset();

    do_reset();
    step(0, 0, 0, 1, 32'h00500093, "boot_step");
    check("boot.addr0", imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'h00500093, "first");
    check("first.idpc", ID_pc, 32'h0);
    check("first.inst", ID_inst, 32'h00500093);
    check("first.valid", {31'b0, ID_valid}, 32'h1);
    check("first.addr", imem_addr, 32'h4);

    step(0, 0, 0, 1, 32'h11111111, "adv");
    check("pre_stall.addr", imem_addr, 32'h8);
    saved_inst = ID_inst;
    step(1, 0, 0, 1, 32'h22222222, "stall");
    check("stall.addr", imem_addr, 32'h8);
    check("stall.idpc", ID_pc, 32'h4);
    check("stall.inst", ID_inst, saved_inst);
    step(0, 0, 0, 1, 32'h33333333, "release");
    check("release.idpc", ID_pc, 32'h8);

    saved_id_pc = ID_pc;
    step(1, 1, 32'h0000_0103, 1, 32'h44444444, "redir_stall");
    check("redir.addr", imem_addr, 32'h0000_0100);
    check("redir.inst", ID_inst, 32'h00000013);
    check("redir.valid", {31'b0, ID_valid}, 32'h0);
    check("redir.idpc", ID_pc, saved_id_pc);

    step(0, 1, 32'h20, 1, 32'h0, "to20");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, $urandom, "wait");
      check("wait.addr", imem_addr, 32'h20);
      check("wait.req", {31'b0, imem_req}, 32'h1);
      check("wait.valid", {31'b0, ID_valid}, 32'h0);
    end
    step(0, 0, 0, 1, 32'h55555555, "wait_done");
    check("wait_done.idpc", ID_pc, 32'h20);

    step(0, 1, 32'hFFFF_FFFC, 1, 32'h0, "to_top");
    step(0, 0, 0, 1, 32'h66666666, "wrap");
    check("wrap.addr", imem_addr, 32'h0);

    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      y = ($urandom_range(0, 3) != 0);
      step(d, r, $urandom, y, $urandom, "rand");
      if (i == 200) do_reset();
    end

    do_reset();
    step(0, 0, 0, 1, 32'h0, "perf_boot");
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom_range(0, 1), $urandom, "perf_stall");
    for (int i = 0; i < 2; i++) step($urandom_range(0, 1), 1, $urandom, 1, $urandom, "perf_flush");
`ifdef PERF_CNT_EN
    check("perf.stall5", perf_stall_cnt, 32'd5);
    check("perf.flush2", perf_flush_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
